// File: rtl/queue_ctrl.sv
// queue_ctrl: assembles serial bits into words and drives the push/pop
// strobes of an external byte queue, with overflow tracking.
module queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int WORD  = 8
) (
    input  logic                     clock_1MHz,
    input  logic                     rst,
    input  logic                     data_in,
    input  logic                     write_in,
    input  logic                     dequeue_in,
    input  logic [$clog2(DEPTH):0]   q_len,
    output logic                     q_enq,
    output logic [WORD-1:0]          q_wdata,
    output logic                     q_deq,
    output logic                     status_out,
    output logic                     overflow_out
);

    localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORD - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;
    localparam logic [1:0] POP  = 2'd3;

    logic [1:0]      wr_s;
    logic [1:0]      dq_s;
    logic [1:0]      dt_s;
    logic            wr_d;
    logic            dq_d;
    logic            wr_stb;
    logic            dq_stb;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [WORD-1:0] shift;
    logic [WORD-1:0] shift_n;
    logic            pending;
    logic            has_room;
    logic            word_done;

    // Two-flop synchronizers plus registered rising-edge strobes.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            wr_s   <= '0;
            dq_s   <= '0;
            dt_s   <= '0;
            wr_d   <= 1'b0;
            dq_d   <= 1'b0;
            wr_stb <= 1'b0;
            dq_stb <= 1'b0;
        end else begin
            wr_s   <= {wr_s[0], write_in};
            dq_s   <= {dq_s[0], dequeue_in};
            dt_s   <= {dt_s[0], data_in};
            wr_d   <= wr_s[1];
            dq_d   <= dq_s[1];
            wr_stb <= wr_s[1] & ~wr_d;
            dq_stb <= dq_s[1] & ~dq_d;
        end
    end

    assign has_room  = (q_len < FULL);
    assign word_done = wr_stb && (cnt == LAST);
    assign q_enq     = (state == PUSH) && has_room;
    assign q_deq     = (state == POP) && (q_len != '0);

    // Bit assembly and next-state selection; bits shift in any state.
    always_comb begin
        shift_n = shift;
        cnt_n   = cnt;
        state_n = state;
        if (wr_stb) begin
            shift_n = {shift[WORD-2:0], dt_s[1]};
            cnt_n   = word_done ? '0 : cnt + CW'(1);
        end
        if (word_done) begin
            state_n = PUSH;
        end else if (pending && (state != POP)) begin
            state_n = POP;
        end else begin
            state_n = (cnt_n == '0) ? IDLE : RECV;
        end
    end

    // FSM, shift register, pending pop request and output registers.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shift        <= '0;
            pending      <= 1'b0;
            q_wdata      <= '0;
            status_out   <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            status_out <= has_room;
            if (state == POP) begin
                pending <= 1'b0;
            end else if (dq_stb) begin
                pending <= 1'b1;
            end
            if (word_done) begin
                q_wdata <= shift_n;
            end
            if ((state == PUSH) && !has_room) begin
                overflow_out <= 1'b1;
            end
        end
    end

endmodule
